// File: rtl/alarm_escalator.sv
// alarm_escalator: debounced alarm-class escalation FSM driving buzzer, indicators and shutdown request
// Ports: clk/rst (async active-high); alarm_leds one-hot class [2]=crit [1]=low [0]=normal;
// pwr_level raw 4-bit power; ack operator acknowledge; clr shutdown clear;
// state FSM code; buzzer/warn/shutdown_req drives; alarm_latched sticky flag; event_count ALARM entries (saturating).
module alarm_escalator #(
  parameter int DEB_CYCLES = 4,
  parameter int BEEP_HALF = 8,
  parameter int ESC_TIMEOUT = 64,
  parameter logic [3:0] PWR_LIMIT = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] alarm_leds,
  input  logic [3:0] pwr_level,
  input  logic       ack,
  input  logic       clr,
  output logic [2:0] state,
  output logic       buzzer,
  output logic       warn,
  output logic       alarm_latched,
  output logic       shutdown_req,
  output logic [7:0] event_count
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int EW = $clog2(ESC_TIMEOUT + 1);
  localparam int BW = $clog2(BEEP_HALF + 1);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WARN = 3'd1, S_ALARM = 3'd2, S_ACKED = 3'd3, S_SHUTDOWN = 3'd4
  } state_t;
  typedef enum logic [1:0] {C_NORM, C_LOW, C_CRIT} cls_t;
  state_t state_q, state_d;
  cls_t cls, cls_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [EW-1:0] esc_q, esc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [7:0] ev_q, ev_d;
  logic buz_q, buz_d, warn_q, warn_d, lat_q, lat_d, sd_q, sd_d;
  logic qual, q_norm, q_low, q_crit, expired, beep_end, enter;
  // Anything that is not exactly 001 or 010 is treated as critical (fail-safe).
  always_comb begin
    cls = alarm_leds == 3'b001 ? C_NORM : alarm_leds == 3'b010 ? C_LOW : C_CRIT;
    deb_d = cls != cls_q ? DW'(1) : deb_q == DW'(DEB_CYCLES) ? deb_q : deb_q + DW'(1);
    qual = deb_q == DW'(DEB_CYCLES);
    q_norm = qual && cls_q == C_NORM;
    q_low = qual && cls_q == C_LOW;
    q_crit = qual && cls_q == C_CRIT;
    expired = esc_q == EW'(ESC_TIMEOUT);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = q_crit ? S_ALARM : q_low ? S_WARN : S_IDLE;
      S_WARN:     state_d = q_crit ? S_ALARM : q_norm ? S_IDLE : S_WARN;
      S_ALARM:    state_d = ack ? S_ACKED : expired && pwr_level >= PWR_LIMIT ? S_SHUTDOWN : S_ALARM;
      S_ACKED:    state_d = q_norm ? S_IDLE : q_low ? S_WARN : S_ACKED;
      S_SHUTDOWN: state_d = clr && alarm_leds == 3'b001 ? S_IDLE : S_SHUTDOWN;
      default:    state_d = S_IDLE;
    endcase
  end
  // Beep phase counter only runs while staying in ALARM; entry restarts it with the buzzer on.
  always_comb begin
    enter = state_d == S_ALARM && state_q != S_ALARM;
    beep_end = beep_q == BW'(BEEP_HALF - 1);
    esc_d = enter ? '0 : state_q == S_ALARM && !expired ? esc_q + EW'(1) : esc_q;
    beep_d = state_d == S_ALARM && state_q == S_ALARM && !beep_end ? beep_q + BW'(1) : '0;
    buz_d = state_d == S_SHUTDOWN || enter || (state_d == S_ALARM && (buz_q ^ beep_end));
    ev_d = enter && ev_q != 8'hff ? ev_q + 8'd1 : ev_q;
    lat_d = enter ? 1'b1 : state_d == S_IDLE ? 1'b0 : lat_q;
    warn_d = state_d == S_WARN;
    sd_d = state_d == S_SHUTDOWN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q <= C_NORM;
      deb_q <= '0;
      esc_q <= '0;
      beep_q <= '0;
      ev_q <= '0;
      buz_q <= 1'b0;
      warn_q <= 1'b0;
      lat_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls;
      deb_q <= deb_d;
      esc_q <= esc_d;
      beep_q <= beep_d;
      ev_q <= ev_d;
      buz_q <= buz_d;
      warn_q <= warn_d;
      lat_q <= lat_d;
      sd_q <= sd_d;
    end
  end
  assign state = state_q;
  assign buzzer = buz_q;
  assign warn = warn_q;
  assign alarm_latched = lat_q;
  assign shutdown_req = sd_q;
  assign event_count = ev_q;
endmodule

// File: doc/alarm_escalator.md
Name: alarm_escalator

Overview:
Downstream consumer of the alarm monitor stage. Takes its one-hot alarm level (alarm_leds) and registered power level (pwr_reg), debounces the alarm class, and runs an escalation FSM: warning, audible alarm, operator acknowledge, and timed shutdown request. Outputs drive the buzzer, status indicators and the supervisor's shutdown input.

Parameters:
DEB_CYCLES, 4, consecutive identical samples needed to qualify an alarm class (>=1)
BEEP_HALF, 8, buzzer half-period in clk cycles while in ALARM (>=1)
ESC_TIMEOUT, 64, cycles in ALARM without ack before shutdown is evaluated (>=1)
PWR_LIMIT, 4'd8, pwr_level at or above which an expired alarm escalates to SHUTDOWN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
alarm_leds  in  3  one-hot class from monitor: [2]=critical, [1]=low, [0]=normal
pwr_level  in  4  monitor power register value, unsigned
ack  in  1  operator acknowledge, single-cycle or level
clr  in  1  shutdown clear request
state  out  3  FSM state code
buzzer  out  1  audible alarm drive
warn  out  1  warning indicator
alarm_latched  out  1  sticky "alarm occurred since last return to IDLE"
shutdown_req  out  1  shutdown request to supervisor
event_count  out  8  count of ALARM entries, saturating

Behaviour:
- Single clock domain. Clock is clk; reset is rst, asynchronous, active-high. All outputs are registered.
- Reset values: state=IDLE(0), buzzer=0, warn=0, alarm_latched=0, shutdown_req=0, event_count=0, and all internal counters 0. Reset mid-operation, including during SHUTDOWN, returns to these values immediately.
- Classification, per sample:
  - CRIT if alarm_leds[2]=1 or alarm_leds is not exactly one-hot (000, 011, 101, 110, 111 are fail-safe CRIT).
  - LOW if the value is 010.
  - NORM if the value is 001.
- Debounce:
  - The counter resets to 1 when the class differs from the previous sample; otherwise it increments, saturating at DEB_CYCLES.
  - A class is qualified while the counter equals DEB_CYCLES.
  - A class first applied before edge 1 becomes qualified at edge DEB_CYCLES. The resulting state change is visible after edge DEB_CYCLES+1.
- State codes: IDLE=0, WARN=1, ALARM=2, ACKED=3, SHUTDOWN=4. Codes 5-7 go to IDLE on the next edge.
- Transitions, evaluated each edge:
  - IDLE: qualified CRIT -> ALARM; qualified LOW -> WARN.
  - WARN: qualified CRIT -> ALARM; qualified NORM -> IDLE.
  - ALARM:
    - ack=1 -> ACKED.
    - Otherwise, once esc_timer has reached ESC_TIMEOUT and pwr_level >= PWR_LIMIT -> SHUTDOWN.
    - ack has priority over shutdown in the same cycle.
  - ACKED: qualified NORM -> IDLE; qualified LOW -> WARN. The system stays ACKED while CRIT persists.
  - SHUTDOWN: clr=1 while the current sample is NORM -> IDLE. clr is ignored otherwise. shutdown_req is sticky.
- esc_timer:
  - Cleared on entry to ALARM, then increments every cycle in ALARM.
  - Saturates at ESC_TIMEOUT. If pwr_level < PWR_LIMIT at expiry, the FSM stays in ALARM and re-checks pwr_level every cycle.
- Buzzer:
  - On entry to ALARM the buzzer goes to 1. It toggles every BEEP_HALF cycles while in ALARM.
  - Constant 1 in SHUTDOWN; 0 in all other states.
- warn=1 only in WARN.
- alarm_latched: set on entry to ALARM; cleared only on entry to IDLE.
- shutdown_req=1 exactly while in SHUTDOWN.
- event_count: +1 on each transition into ALARM; holds at 255.
- ack outside ALARM is ignored. A held ack does not skip ACKED on a later re-entry, because ACKED never transitions directly to ALARM.
- pwr_level is sampled raw, with no debounce. Width is 4-bit unsigned; the comparison is unsigned.

Test Plan:
- Reset, then alarm_leds=001 for 20 cycles -> state=0, all outputs 0, event_count=0.
- alarm_leds=100 held (DEB_CYCLES=4) -> state=2 after edge 5. Then buzzer=1 for 8 cycles, 0 for 8 cycles, and so on; alarm_latched=1; event_count=1. A 3-cycle 100 glitch in IDLE -> no state change.
- ALARM, then ack pulse at cycle 10 -> state=3, buzzer=0. Then 001 for 4 cycles -> state=0 and alarm_latched=0.
- ALARM with pwr_level=9, no ack -> state=4 after the ESC_TIMEOUT expiry edge, shutdown_req=1, buzzer=1. clr while input is 100 -> stays 4. clr with input 001 -> state=0.
- ALARM with pwr_level=7 for 100 cycles -> remains 2. pwr_level changes to 8 -> state=4 next edge. ack and expiry in the same cycle with pwr_level=15 -> state=3.
- alarm_leds=110 for 4 cycles -> treated as CRIT, state=2. Sequence 010 x4 -> WARN, warn=1. Then rst asserted asynchronously mid-SHUTDOWN -> all outputs 0 without a clock edge. Drive 256 ALARM entries -> event_count=255.
